edc_scrubber: RTL and testbench
===============================

# edc_scrubber

Background scrubbing controller for the EDC-protected data-cache array (512 words × 32 data bits + 7 check bits). It periodically sweeps every word through the array's shared access port and classifies each word with the external EDC decoder. Single-bit errors are corrected and written back; double-bit errors are logged and flagged. The pipeline always has priority on the array port, and the scrubber only uses idle cycles.

## Interface
Parameters:
- ADDR_W, 9, array address width
- DEPTH, 512, words per sweep (addresses 0..DEPTH-1)
- INTERVAL, 1024, idle cycles between sweeps (≥1)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  scrubbing allowed
- clear_counts  in  1  zero ce_count/ue_count
- cpu_req  in  1  pipeline uses the array port this cycle (priority)
- cpu_wr  in  1  pipeline writes the array this cycle
- cpu_addr  in  ADDR_W  pipeline array address
- arr_re  out  1  scrub read strobe
- arr_addr  out  ADDR_W  scrub address
- arr_rdata  in  32  read data, valid the cycle after arr_re
- arr_rpar  in  7  read check bits, same timing
- dec_single  in  1  decoder: correctable error on arr_rdata/arr_rpar
- dec_double  in  1  decoder: uncorrectable error
- dec_data  in  32  decoder corrected data
- dec_par  in  7  decoder recomputed check bits
- arr_dwe, arr_pwe  out  1  write-back strobes (always asserted together)
- arr_din  out  32  write-back data
- arr_pin  out  7  write-back check bits
- busy  out  1  state ≠ IDLE
- sweep_done  out  1  one-cycle pulse at end of sweep
- ue_irq  out  1  one-cycle pulse on uncorrectable error
- ce_count, ue_count  out  16  saturating error counters
- last_ue_addr  out  ADDR_W  address of the most recent uncorrectable error

## Operation
- States: IDLE, READ, CHECK, WRITE, NEXT.
- IDLE: while enable=1, the interval counter increments. It moves to READ when the counter reaches INTERVAL-1. enable=0 clears the counter.
- READ: if cpu_req=1, the state is held and arr_re=0. Otherwise arr_re=1 with arr_addr=scrub address, then the block moves to CHECK.
- CHECK: samples the decoder outputs.
  - dec_double: ue_count+1, last_ue_addr←address, ue_irq pulse (registered, the next cycle), then NEXT with no write.
  - Else dec_single: ce_count+1, latch dec_data/dec_par, clear the hazard flag, then WRITE.
  - Else: NEXT.
- Hazard: a cpu_wr with cpu_addr equal to the scrub address, seen in CHECK or WRITE, sets the hazard flag. The pending write-back is then dropped, because the pipeline data is newer. The counter is still incremented.
- WRITE: if the hazard flag is set, go to NEXT with no strobes. If cpu_req=1, hold. Otherwise arr_dwe=arr_pwe=1, arr_din/arr_pin=latched values, then NEXT.
- NEXT:
  - If address = DEPTH-1: sweep_done pulse, address←0, then IDLE.
  - Else if enable=0: address+1, then IDLE (the sweep resumes from that address after the next interval).
  - Else: address+1, then READ.
- The address wraps modulo DEPTH. Counters saturate at 16'hFFFF. clear_counts takes precedence over a same-cycle increment.
- enable only affects IDLE and NEXT. A word already in flight always completes.

## Timing
- Reset: state IDLE; address, interval counter, ce_count, ue_count and last_ue_addr are 0; all strobes and pulses are 0.
- Strobes (arr_re, arr_dwe, arr_pwe) are combinational from state and cpu_req, and are never high while cpu_req=1.
- First arr_re occurs INTERVAL cycles after the first edge at which enable is sampled high.
- Clean word: 3 cycles (READ, CHECK, NEXT). Corrected word: 4 cycles. Each cycle of cpu_req stall adds 1.
- Clean, uncontended sweep: DEPTH×3 cycles.
- A rst asserted in any state returns the block to the reset values at the next edge. No write-back is issued on that edge.

## Test plan
- INTERVAL=4, clean array, enable held → first arr_re 4 cycles after enable; arr_re addresses 0,1,2… every 3 cycles; sweep_done after 1536 cycles; counts stay 0.
- Inject a 1-bit data error at address 1 (data←3) → at address 1, a single cycle of arr_dwe=arr_pwe=1 with decoder-corrected data; ce_count=1.
- Inject 2-bit errors at address 3 (data 5, check bits 7'b1000111) → ue_count=1, last_ue_addr=3, one ue_irq pulse, no write at address 3.
- cpu_req high for 10 cycles while in READ → arr_re=0 for those 10 cycles and asserted the cycle after cpu_req falls; address unchanged.
- Single error at address 1 plus cpu_wr to address 1 during CHECK → no write-back strobes; ce_count=1.
- rst pulsed during WRITE → the next cycle shows busy=0, counts 0, no arr_dwe; after release, scrubbing restarts from address 0 after INTERVAL cycles.

Source files
------------

// File: rtl/edc_scrubber.sv
// edc_scrubber -- background scrubber for the EDC-protected data-cache array.
//
// Walks every word of the array through the shared access port during idle
// cycles. Each word is read, classified by the external EDC decoder, and
// either left alone (clean), written back corrected (single-bit error), or
// logged and flagged (double-bit error).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enable            scrubbing allowed (acts in IDLE and NEXT only)
//   clear_counts      zero ce_count / ue_count (wins over an increment)
//   cpu_req/wr/addr   pipeline use of the array port (always has priority)
//   arr_re, arr_addr  scrub read strobe and scrub address
//   arr_rdata/rpar    array read data, valid the cycle after arr_re
//   dec_*             external decoder results for arr_rdata/arr_rpar
//   arr_dwe/pwe       write-back strobes, arr_din/arr_pin write-back values
//   busy              scrubber is not IDLE
//   sweep_done        one-cycle pulse after the last word of a sweep
//   ue_irq            one-cycle pulse after an uncorrectable word
//   ce_count/ue_count saturating error counters
//   last_ue_addr      address of the most recent uncorrectable word
//
// Port arbitration: the pipeline owns the array whenever cpu_req=1. The
// scrubber's strobes are combinational from its state and cpu_req and are
// forced low while cpu_req=1; READ and WRITE simply wait for a free cycle.
// A strobe high in a cycle means the access happens at that cycle's edge.
module edc_scrubber #(
    parameter int ADDR_W   = 9,
    parameter int DEPTH    = 512,
    parameter int INTERVAL = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear_counts,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              arr_re,
    output logic [ADDR_W-1:0] arr_addr,
    input  logic [31:0]       arr_rdata,
    input  logic [6:0]        arr_rpar,
    input  logic              dec_single,
    input  logic              dec_double,
    input  logic [31:0]       dec_data,
    input  logic [6:0]        dec_par,
    output logic              arr_dwe,
    output logic              arr_pwe,
    output logic [31:0]       arr_din,
    output logic [6:0]        arr_pin,
    output logic              busy,
    output logic              sweep_done,
    output logic              ue_irq,
    output logic [15:0]       ce_count,
    output logic [15:0]       ue_count,
    output logic [ADDR_W-1:0] last_ue_addr
);

    localparam int CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [CNT_W-1:0]  INT_LAST  = CNT_W'(INTERVAL - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        WRITE,
        NEXT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  int_cnt;
    logic              hazard;
    logic [31:0]       wb_data;
    logic [6:0]        wb_par;

    // The raw read word is consumed by the external decoder; this block only
    // acts on the decoder's verdict and corrected values.
    logic unused_rd;
    assign unused_rd = ^{arr_rdata, arr_rpar};

    // Pipeline store to the word currently being scrubbed: its data is newer
    // than anything the scrubber could write back.
    logic hz_now;
    assign hz_now = cpu_wr && (cpu_addr == addr);

    logic ce_inc;
    logic ue_inc;
    assign ue_inc = (state == CHECK) && dec_double;
    assign ce_inc = (state == CHECK) && !dec_double && dec_single;

    // rst gates the strobes so that nothing reaches the array on a reset edge.
    logic do_write;
    assign do_write = (state == WRITE) && !hazard && !hz_now && !cpu_req && !rst;

    assign arr_re   = (state == READ) && !cpu_req && !rst;
    assign arr_addr = addr;
    assign arr_dwe  = do_write;
    assign arr_pwe  = do_write;
    assign arr_din  = wb_data;
    assign arr_pin  = wb_par;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr         <= '0;
            int_cnt      <= '0;
            hazard       <= 1'b0;
            wb_data      <= '0;
            wb_par       <= '0;
            ce_count     <= '0;
            ue_count     <= '0;
            last_ue_addr <= '0;
            sweep_done   <= 1'b0;
            ue_irq       <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            ue_irq     <= 1'b0;

            if (clear_counts) begin
                ce_count <= '0;
                ue_count <= '0;
            end else begin
                if (ce_inc && (ce_count != 16'hFFFF)) ce_count <= ce_count + 16'd1;
                if (ue_inc && (ue_count != 16'hFFFF)) ue_count <= ue_count + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (!enable) begin
                        int_cnt <= '0;
                    end else if (int_cnt == INT_LAST) begin
                        int_cnt <= '0;
                        state   <= READ;
                    end else begin
                        int_cnt <= int_cnt + CNT_W'(1);
                    end
                end
                READ: begin
                    if (!cpu_req) state <= CHECK;
                end
                CHECK: begin
                    if (dec_double) begin
                        last_ue_addr <= addr;
                        ue_irq       <= 1'b1;
                        state        <= NEXT;
                    end else if (dec_single) begin
                        wb_data <= dec_data;
                        wb_par  <= dec_par;
                        // A store seen in this same cycle already invalidates
                        // the correction we are about to latch.
                        hazard  <= hz_now;
                        state   <= WRITE;
                    end else begin
                        state <= NEXT;
                    end
                end
                WRITE: begin
                    // A hazard (flagged earlier or seen now) drops the
                    // write-back; otherwise wait for a free port cycle.
                    if (hazard || hz_now || !cpu_req) state <= NEXT;
                end
                NEXT: begin
                    if (addr == ADDR_LAST) begin
                        sweep_done <= 1'b1;
                        addr       <= '0;
                        state      <= IDLE;
                    end else begin
                        addr  <= addr + ADDR_W'(1);
                        state <= enable ? READ : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_edc_scrubber.sv
// tb_edc_scrubber -- self-checking bench for edc_scrubber.
//
// The bench owns a behavioural array (observed contents plus a golden copy)
// and a stand-in decoder that classifies a read word by how many bits differ
// from the golden copy. Expected traffic for a sweep is predicted from the
// array contents: every address read in order, 3 cycles per clean word,
// 4 per correctable word, write-backs of golden data, irq per bad word.
module tb_edc_scrubber;

    localparam int ADDR_W   = 9;
    localparam int DEPTH    = 512;
    localparam int INTERVAL = 4;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, enable, clear_counts, cpu_req, cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              arr_re, arr_dwe, arr_pwe, busy, sweep_done, ue_irq;
    logic [ADDR_W-1:0] arr_addr, last_ue_addr;
    logic [31:0]       arr_din;
    logic [6:0]        arr_pin;
    logic [15:0]       ce_count, ue_count;
    logic [31:0]       rdata = '0;
    logic [6:0]        rpar = '0;
    logic [ADDR_W-1:0] raddr = '0;
    logic              dec_single, dec_double;
    logic [31:0]       dec_data;
    logic [6:0]        dec_par;

    edc_scrubber #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .INTERVAL(INTERVAL)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear_counts(clear_counts),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .arr_re(arr_re), .arr_addr(arr_addr),
        .arr_rdata(rdata), .arr_rpar(rpar),
        .dec_single(dec_single), .dec_double(dec_double),
        .dec_data(dec_data), .dec_par(dec_par),
        .arr_dwe(arr_dwe), .arr_pwe(arr_pwe), .arr_din(arr_din), .arr_pin(arr_pin),
        .busy(busy), .sweep_done(sweep_done), .ue_irq(ue_irq),
        .ce_count(ce_count), .ue_count(ue_count), .last_ue_addr(last_ue_addr)
    );

    // ---------------- array and decoder model ----------------
    logic [31:0] mem_d[DEPTH];
    logic [6:0]  mem_p[DEPTH];
    logic [31:0] gold_d[DEPTH];
    logic [6:0]  gold_p[DEPTH];

    logic              poke_en = 1'b0;
    logic [ADDR_W-1:0] poke_addr = '0;
    logic [31:0]       poke_md = '0, poke_gd = '0;
    logic [6:0]        poke_mp = '0, poke_gp = '0;

    function automatic logic [6:0] chk(input logic [31:0] d);
        return d[6:0] ^ d[13:7] ^ d[20:14] ^ d[27:21] ^ {3'b000, d[31:28]};
    endfunction

    always @(posedge clk) begin
        if (arr_re) begin
            rdata <= mem_d[arr_addr];
            rpar  <= mem_p[arr_addr];
            raddr <= arr_addr;
        end
        if (arr_dwe) begin
            mem_d[arr_addr] <= arr_din;
            mem_p[arr_addr] <= arr_pin;
        end
        if (cpu_wr) begin
            mem_d[cpu_addr]  <= cpu_wdata;
            mem_p[cpu_addr]  <= chk(cpu_wdata);
            gold_d[cpu_addr] <= cpu_wdata;
            gold_p[cpu_addr] <= chk(cpu_wdata);
        end
        if (poke_en) begin
            mem_d[poke_addr]  <= poke_md;
            mem_p[poke_addr]  <= poke_mp;
            gold_d[poke_addr] <= poke_gd;
            gold_p[poke_addr] <= poke_gp;
        end
    end

    int nbits;
    always_comb begin
        nbits      = $countones(rdata ^ gold_d[raddr]) + $countones(rpar ^ gold_p[raddr]);
        dec_single = (nbits == 1);
        dec_double = (nbits >= 2);
        dec_data   = gold_d[raddr];
        dec_par    = gold_p[raddr];
    end

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        int          addr;
        logic [31:0] d;
        logic [6:0]  p;
        logic        both;
    } ev_t;

    ev_t         re_q[$];
    ev_t         wr_q[$];
    int          irq_q[$];
    int          sd_q[$];
    logic [47:0] exp_q[$];      // expected write-backs {addr, data, par}
    int          exp_wr_cyc[$];
    int          exp_irq_q[$];
    int          re_cyc[DEPTH];
    int          done_cyc;
    int          exp_ce = 0, exp_ue = 0, exp_last_ue = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, one entry per cycle of activity.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cpu_req) check("strobe_under_cpu_req", {arr_re, arr_dwe, arr_pwe}, 0);
        if (arr_re) re_q.push_back('{cyc, int'(arr_addr), 32'h0, 7'h0, 1'b0});
        if (arr_dwe || arr_pwe)
            wr_q.push_back('{cyc, int'(arr_addr), arr_din, arr_pin, arr_dwe && arr_pwe});
        if (ue_irq) irq_q.push_back(cyc);
        if (sweep_done) sd_q.push_back(cyc);
    end

    // ---------------- reference model ----------------
    function automatic int nerr(input int a);
        return $countones(mem_d[a] ^ gold_d[a]) + $countones(mem_p[a] ^ gold_p[a]);
    endfunction

    task automatic predict(input int start, input int stall, input int hz_addr);
        int t;
        int n;
        t = start + INTERVAL + stall;
        exp_q.delete();
        exp_wr_cyc.delete();
        exp_irq_q.delete();
        for (int a = 0; a < DEPTH; a++) begin
            n = nerr(a);
            re_cyc[a] = t;
            if (n == 0) begin
                t += 3;
            end else if (n == 1) begin
                if (exp_ce < 65535) exp_ce++;
                if (a != hz_addr) begin
                    exp_q.push_back({ADDR_W'(a), gold_d[a], gold_p[a]});
                    exp_wr_cyc.push_back(t + 2);
                end
                t += 4;
            end else begin
                if (exp_ue < 65535) exp_ue++;
                exp_last_ue = a;
                exp_irq_q.push_back(t + 2);
                t += 3;
            end
        end
        done_cyc = t;
    endtask

    // ---------------- driver tasks ----------------
    // All drivers run from one posedge+#1 point to the next.
    task automatic poke(input int a, input logic [31:0] md, input logic [6:0] mp,
                        input logic [31:0] gd, input logic [6:0] gp);
        poke_en   = 1'b1;
        poke_addr = ADDR_W'(a);
        poke_md   = md;
        poke_mp   = mp;
        poke_gd   = gd;
        poke_gp   = gp;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic clear_logs();
        re_q.delete();
        wr_q.delete();
        irq_q.delete();
        sd_q.delete();
    endtask

    task automatic run_sweep(input string name, input int stall, input int hz_addr,
                             input logic [31:0] hz_data);
        int start, r0, hz_cyc, nc;
        bit done;
        clear_logs();
        start  = cyc + 1;
        enable = 1'b1;
        predict(start, stall, hz_addr);
        r0     = start + INTERVAL;
        hz_cyc = (hz_addr >= 0) ? re_cyc[hz_addr] + 1 : -1;
        done   = 1'b0;
        for (int k = 0; k < 4000 && !done; k++) begin
            @(posedge clk); #1;
            nc = cyc + 1;
            cpu_req = 1'b0;
            cpu_wr  = 1'b0;
            if (nc >= r0 && nc < r0 + stall) cpu_req = 1'b1;
            if (nc == hz_cyc) begin
                cpu_req   = 1'b1;
                cpu_wr    = 1'b1;
                cpu_addr  = ADDR_W'(hz_addr);
                cpu_wdata = hz_data;
            end
            if (stall > 0 && nc == r0 + stall - 1)
                check($sformatf("%s_addr_held_in_stall", name), arr_addr, 0);
            if (sd_q.size() > 0) done = 1'b1;
        end
        cpu_req = 1'b0;
        cpu_wr  = 1'b0;
        enable  = 1'b0;
        check($sformatf("%s_sweep_finished", name), done, 1);

        check($sformatf("%s_re_count", name), re_q.size(), DEPTH);
        if (re_q.size() > 0)
            check($sformatf("%s_first_re_delay", name), re_q[0].cyc - start, INTERVAL + stall);
        begin
            int bad = 0;
            for (int a = 0; a < DEPTH && a < re_q.size(); a++)
                if (re_q[a].addr != a || re_q[a].cyc != re_cyc[a]) bad++;
            check($sformatf("%s_re_order_and_timing_errors", name), bad, 0);
        end
        check($sformatf("%s_wr_count", name), wr_q.size(), exp_q.size());
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_wr_word", name),
                  {ADDR_W'(wr_q[i].addr), wr_q[i].d, wr_q[i].p}, exp_q[i]);
            check($sformatf("%s_wr_cycle", name), wr_q[i].cyc, exp_wr_cyc[i]);
            check($sformatf("%s_wr_both_strobes", name), wr_q[i].both, 1);
        end
        check($sformatf("%s_irq_count", name), irq_q.size(), exp_irq_q.size());
        for (int i = 0; i < irq_q.size() && i < exp_irq_q.size(); i++)
            check($sformatf("%s_irq_cycle", name), irq_q[i], exp_irq_q[i]);
        check($sformatf("%s_sweep_done_count", name), sd_q.size(), 1);
        if (sd_q.size() > 0)
            check($sformatf("%s_sweep_done_cycle", name), sd_q[0], done_cyc);
        check($sformatf("%s_ce_count", name), ce_count, exp_ce);
        check($sformatf("%s_ue_count", name), ue_count, exp_ue);
        check($sformatf("%s_last_ue_addr", name), last_ue_addr, exp_last_ue);
    endtask

    task automatic flip_bits(input int a, input int nflip);
        logic [38:0] v;
        int b0, b1;
        v  = {gold_d[a], gold_p[a]};
        b0 = $urandom_range(0, 38);
        b1 = (b0 + $urandom_range(1, 38)) % 39;
        v[b0] = ~v[b0];
        if (nflip > 1) v[b1] = ~v[b1];
        poke(a, v[38:7], v[6:0], gold_d[a], gold_p[a]);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    bit          used[DEPTH];
    logic [31:0] d;
    logic [31:0] hz_data;
    int          a, rst_cyc;

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        clear_counts = 1'b0;
        cpu_req      = 1'b0;
        cpu_wr       = 1'b0;
        cpu_addr     = '0;
        cpu_wdata    = '0;
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            poke(i, d, chk(d), d, chk(d));
            used[i] = 1'b0;
        end

        // Reset values while rst is held.
        check("rst_busy", busy, 0);
        check("rst_arr_re", arr_re, 0);
        check("rst_arr_dwe", {arr_dwe, arr_pwe}, 0);
        check("rst_sweep_done", sweep_done, 0);
        check("rst_ue_irq", ue_irq, 0);
        check("rst_ce_count", ce_count, 0);
        check("rst_ue_count", ue_count, 0);
        check("rst_last_ue_addr", last_ue_addr, 0);
        check("rst_arr_addr", arr_addr, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Clean array, enable held for one full sweep.
        run_sweep("clean", 0, -1, 32'h0);

        // Directed single at 1 and double at 3, plus random bad words.
        poke(1, 32'h3, chk(32'h2), 32'h2, chk(32'h2));
        poke(3, 32'h5, 7'b1000111, 32'h5, chk(32'h5));
        used[1] = 1'b1;
        used[3] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a = $urandom_range(8, DEPTH - 1);
            while (used[a]) a = $urandom_range(8, DEPTH - 1);
            used[a] = 1'b1;
            flip_bits(a, (i < 4) ? 1 : 2);
        end
        // Pipeline holds the port for 10 cycles at the first READ.
        run_sweep("errors_stall", 10, -1, 32'h0);
        check("corrected_data_addr1", mem_d[1], 32'h2);
        check("corrected_par_addr1", mem_p[1], chk(32'h2));
        check("no_write_addr3_par", mem_p[3], 7'b1000111);

        // Single at 1 again, but the pipeline stores to 1 during CHECK.
        poke(1, 32'h3, chk(32'h2), 32'h2, chk(32'h2));
        hz_data = $urandom;
        run_sweep("hazard", 0, 1, hz_data);
        check("hazard_pipeline_data_kept", mem_d[1], hz_data);
        begin
            int n1 = 0;
            foreach (wr_q[i]) if (wr_q[i].addr == 1) n1++;
            check("hazard_no_writeback_addr1", n1, 0);
        end

        // Counter clear.
        clear_counts = 1'b1;
        @(posedge clk); #1;
        clear_counts = 1'b0;
        exp_ce = 0;
        exp_ue = 0;
        check("clear_ce_count", ce_count, 0);
        check("clear_ue_count", ue_count, 0);
        check("clear_keeps_last_ue", last_ue_addr, exp_last_ue);

        // Reset while the correction for address 1 sits in WRITE.
        poke(1, hz_data ^ 32'h1, chk(hz_data), hz_data, chk(hz_data));
        clear_logs();
        enable = 1'b1;
        predict(cyc + 1, 0, -1);
        rst_cyc = re_cyc[1] + 2;
        for (int k = 0; k < 100 && (cyc + 1) != rst_cyc; k++) begin
            @(posedge clk); #1;
        end
        check("pre_rst_in_write_busy", busy, 1);
        check("pre_rst_ce_count", ce_count, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ce = 0;
        exp_ue = 0;
        exp_last_ue = 0;
        check("post_rst_busy", busy, 0);
        check("post_rst_ce_count", ce_count, 0);
        check("post_rst_ue_count", ue_count, 0);
        check("post_rst_last_ue_addr", last_ue_addr, 0);
        check("post_rst_arr_addr", arr_addr, 0);
        for (int k = 0; k < 50 && re_q.size() < 3; k++) begin
            @(posedge clk); #1;
        end
        check("rst_no_writeback", wr_q.size(), 0);
        check("rst_restart_re_count", re_q.size(), 3);
        if (re_q.size() >= 3) begin
            check("rst_restart_addr", re_q[2].addr, 0);
            check("rst_restart_cycle", re_q[2].cyc, rst_cyc + 1 + INTERVAL);
        end
        enable = 1'b0;
        rst    = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("final_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
